// File: rtl/io_map_pkg.sv
// Shared IO-bus address map and debounce constants for the board input path.
package io_map_pkg;

  localparam logic [31:0] IO_ADDR_SW      = 32'h0000_0001;
  localparam logic [31:0] IO_ADDR_BTN     = 32'h0000_0002;
  localparam logic [31:0] IO_ADDR_BTN_EVT = 32'h0000_0003;
  localparam logic [31:0] IO_ADDR_LED     = 32'h0000_0004;

  localparam int unsigned DB_CNT_W = 3;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SW,
    SEL_BTN,
    SEL_EVT
  } rd_sel_e;

  // Full 32-bit compare; the LED address belongs to the top-level write decode.
  function automatic rd_sel_e decode_addr(input logic [31:0] addr);
    rd_sel_e sel;
    sel = SEL_NONE;
    unique case (addr)
      IO_ADDR_SW:      sel = SEL_SW;
      IO_ADDR_BTN:     sel = SEL_BTN;
      IO_ADDR_BTN_EVT: sel = SEL_EVT;
      IO_ADDR_LED:     sel = SEL_NONE;
      default:         sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser followed by a tick-sampled
// consecutive-difference counter that commits a new stable level.
module debounce_bit
  import io_map_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(STABLE_TICKS - 1);

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced switch/button inputs with sticky W1C button events, exposed as
// an IO-bus read slave with a registered read port and level interrupt.
module io_input_conditioner
  import io_map_pkg::*;
#(
  parameter int unsigned SW_WIDTH     = 16,
  parameter int unsigned BTN_WIDTH    = 5,
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  input  logic [BTN_WIDTH-1:0] btn_raw,
  input  logic [31:0]          io_address,
  input  logic                 io_read_en,
  input  logic                 io_write_en,
  input  logic [31:0]          io_write_value,
  output logic [31:0]          io_read_value,
  output logic                 btn_irq
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [BTN_WIDTH-1:0] btn_stable;
  logic [BTN_WIDTH-1:0] btn_prev_q;
  logic [BTN_WIDTH-1:0] evt_q, evt_d;
  logic [BTN_WIDTH-1:0] evt_clr;
  logic                 irq_q;
  logic [31:0]          rd_q, rd_d;
  logic                 unused_wdata;

  assign unused_wdata = ^io_write_value[31:BTN_WIDTH];

  always_comb begin
    tick_d  = (presc_q == PRESC_LAST);
    presc_d = tick_d ? '0 : presc_q + 1'b1;
  end

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick_q),
      .raw    (sw_raw[g]),
      .stable (sw_stable[g])
    );
  end

  for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick_q),
      .raw    (btn_raw[g]),
      .stable (btn_stable[g])
    );
  end

  // Rising-edge set is OR'd after the clear so a same-cycle W1C cannot lose it.
  always_comb begin
    evt_clr = '0;
    if (io_write_en && (io_address == IO_ADDR_BTN_EVT)) begin
      evt_clr = io_write_value[BTN_WIDTH-1:0];
    end
    evt_d = (evt_q & ~evt_clr) | (btn_stable & ~btn_prev_q);
  end

  always_comb begin
    rd_d = rd_q;
    if (io_read_en) begin
      unique case (decode_addr(io_address))
        SEL_SW:  rd_d = 32'(sw_stable);
        SEL_BTN: rd_d = 32'(btn_stable);
        SEL_EVT: rd_d = 32'(evt_q);
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      btn_prev_q <= '0;
      evt_q      <= '0;
      irq_q      <= 1'b0;
      rd_q       <= '0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      btn_prev_q <= btn_stable;
      evt_q      <= evt_d;
      irq_q      <= |evt_q;
      rd_q       <= rd_d;
    end
  end

  assign io_read_value = rd_q;
  assign btn_irq       = irq_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboarded directed bench: reads push expectations, a monitor checks them.
module tb_io_input_conditioner;

  localparam logic [31:0] A_SW  = 32'h1;
  localparam logic [31:0] A_BTN = 32'h2;
  localparam logic [31:0] A_EVT = 32'h3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [4:0]  btn_raw = '0;
  logic [31:0] io_address = '0;
  logic        io_read_en = 1'b0;
  logic        io_write_en = 1'b0;
  logic [31:0] io_write_value = '0;
  logic [31:0] io_read_value;
  logic        btn_irq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc;
  logic rd_issued = 1'b0;

  io_input_conditioner #(
    .SW_WIDTH     (16),
    .BTN_WIDTH    (5),
    .TICK_CYCLES  (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_raw         (sw_raw),
    .btn_raw        (btn_raw),
    .io_address     (io_address),
    .io_read_en     (io_read_en),
    .io_write_en    (io_write_en),
    .io_write_value (io_write_value),
    .io_read_value  (io_read_value),
    .btn_irq        (btn_irq)
  );

  always #5 clk = ~clk;

  // Edge count since reset release: edge 1 is the first posedge with rst_n high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) rd_issued <= io_read_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_issued) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", io_read_value);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, io_read_value, mon_e.exp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_read_value", io_read_value, 32'h0);
    check("rst_irq", {31'h0, btn_irq}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Read issued so that the DUT samples io_read_en on edge n.
  task automatic rd_at(input int n, input logic [31:0] a, input logic [31:0] exp, input string name);
    wait_cyc(n - 1);
    io_address = a;
    io_read_en = 1'b1;
    sb.push_back('{name, exp});
    @(posedge clk);
    #1 io_read_en = 1'b0;
  endtask

  task automatic wr_at(input int n, input logic [31:0] a, input logic [31:0] d);
    wait_cyc(n - 1);
    io_address     = a;
    io_write_value = d;
    io_write_en    = 1'b1;
    @(posedge clk);
    #1 io_write_en = 1'b0;
  endtask

  task automatic rdwr_at(input int n, input logic [31:0] d, input logic [31:0] exp, input string name);
    wait_cyc(n - 1);
    io_address     = A_EVT;
    io_write_value = d;
    io_write_en    = 1'b1;
    io_read_en     = 1'b1;
    sb.push_back('{name, exp});
    @(posedge clk);
    #1;
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and switch debounce timing (samples at edges 5, 9, 13, ...)
    do_reset();
    rd_at(1, A_SW, 32'h0, "sw_after_reset");
    sw_raw = 16'hFFFF;
    rd_at(14, A_SW, 32'h0000FFFF, "sw_settled");
    do_reset();
    rd_at(1, A_SW, 32'h0, "sw_restart");
    rd_at(13, A_SW, 32'h0, "sw_before_3_ticks");
    rd_at(14, A_SW, 32'h0000FFFF, "sw_after_3_ticks");
    check("sw_irq_idle", {31'h0, btn_irq}, 32'h0);

    // Glitch reject, then accepted press
    sw_raw = '0;
    btn_raw = '0;
    do_reset();
    wait_cyc(3);
    btn_raw[0] = 1'b1;
    wait_cyc(11);
    btn_raw[0] = 1'b0;
    rd_at(20, A_BTN, 32'h0, "glitch_btn");
    rd_at(21, A_EVT, 32'h0, "glitch_evt");
    check("glitch_irq", {31'h0, btn_irq}, 32'h0);
    btn_raw[0] = 1'b1;
    rd_at(33, A_BTN, 32'h0, "press_btn_early");
    rd_at(34, A_BTN, 32'h1, "press_btn");
    check("press_irq_early", {31'h0, btn_irq}, 32'h0);
    rd_at(35, A_EVT, 32'h1, "press_evt");
    check("press_irq", {31'h0, btn_irq}, 32'h1);

    // Sticky events and write-1-to-clear
    btn_raw = '0;
    do_reset();
    wait_cyc(1);
    btn_raw = 5'b01010;
    rd_at(16, A_EVT, 32'h0A, "sticky_evt");
    btn_raw = '0;
    rd_at(31, A_EVT, 32'h0A, "sticky_after_release");
    rd_at(32, A_BTN, 32'h0, "released_btn");
    wr_at(33, A_EVT, 32'h08);
    rd_at(34, A_EVT, 32'h02, "w1c_bit3");
    check("w1c_irq_held", {31'h0, btn_irq}, 32'h1);
    wr_at(35, A_EVT, 32'h02);
    check("w1c_irq_lag", {31'h0, btn_irq}, 32'h1);
    rd_at(36, A_EVT, 32'h0, "w1c_all");
    check("w1c_irq_drop", {31'h0, btn_irq}, 32'h0);

    // Set-wins collision; btn[0] held through reset
    btn_raw = 5'b00001;
    do_reset();
    wait_cyc(5);
    btn_raw[2] = 1'b1;
    rd_at(16, A_EVT, 32'h01, "held_through_reset");
    wr_at(18, A_EVT, 32'h05);
    rd_at(19, A_EVT, 32'h04, "set_wins");
    rdwr_at(20, 32'h04, 32'h04, "rdwr_pre_value");
    rd_at(21, A_EVT, 32'h0, "rdwr_cleared");

    // Bus decode and read hold
    sw_raw = 16'h1234;
    btn_raw = 5'b10000;
    do_reset();
    rd_at(15, A_SW, 32'h1234, "decode_sw");
    rd_at(16, 32'h0, 32'h0, "decode_0x0");
    rd_at(17, 32'h4, 32'h0, "decode_0x4");
    rd_at(18, 32'h80000001, 32'h0, "decode_hi_alias");
    rd_at(19, A_SW, 32'h1234, "decode_sw_again");
    wr_at(20, 32'h1, 32'hFF);
    wr_at(21, 32'h2, 32'hFF);
    wr_at(22, 32'h4, 32'hFF);
    wr_at(23, 32'h80000003, 32'hFF);
    rd_at(24, A_EVT, 32'h10, "decode_writes_ignored");
    rd_at(25, A_SW, 32'h1234, "hold_load");
    io_address = A_EVT;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("read_hold", io_read_value, 32'h1234);

    // Switch bounce: odd-edge highs alias away from the tick samples
    sw_raw = '0;
    btn_raw = '0;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      io_address = A_SW;
      io_read_en = 1'b1;
      sb.push_back('{"bounce_sw7", (e >= 34) ? 32'h80 : 32'h0});
      @(posedge clk);
      #1;
      sw_raw[7] = (e <= 20) ? (e % 2 == 1) : 1'b1;
    end
    io_read_en = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Conditions the raw board inputs (16 switches, 5 buttons) before the Risc32 reads them over the memory-mapped IO bus.
- Each input is synchronised into the `clk` domain, then debounced.
- Button presses are captured as sticky events that software clears.
- The block is an IO-bus slave and replaces direct pin sampling in the top-level read mux.

Parameters:
- SW_WIDTH, 16, number of switch inputs
- BTN_WIDTH, 5, number of button inputs
- TICK_CYCLES, 100000, clk cycles per debounce sample tick (1 ms at 100 MHz)
- STABLE_TICKS, 4, consecutive differing ticks needed to accept a new level (range 1..7)

Ports:
- clk  in  1  system clock (CLK100MHZ at top)
- rst_n  in  1  asynchronous active-low reset
- sw_raw  in  SW_WIDTH  raw switch pins, asynchronous
- btn_raw  in  BTN_WIDTH  raw button pins, asynchronous, 1 = pressed
- io_address  in  32  IO bus address
- io_read_en  in  1  IO read strobe
- io_write_en  in  1  IO write strobe
- io_write_value  in  32  IO write data
- io_read_value  out  32  registered read data
- btn_irq  out  1  high while any button event bit is set

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0, all of the following are 0:
  - sync flops, prescaler, tick, per-bit counters
  - debounced levels, btn_event, io_read_value, btn_irq
- Synchroniser: two flops per input bit. Synced value lags the pin by 2 cycles.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick pulses for 1 cycle when count = TICK_CYCLES-1.
  - The first tick occurs TICK_CYCLES cycles after reset release.
- Per-bit debounce, evaluated on tick only:
  - If synced = stable, clear the counter.
  - Otherwise increment the counter.
  - When the counter would reach STABLE_TICKS: stable <= synced, counter <= 0.
  - A glitch shorter than STABLE_TICKS consecutive ticks never changes stable.
  - The counter never exceeds STABLE_TICKS-1.
- Button event:
  - btn_event[i] sets on the cycle after btn_stable[i] goes 0->1 (rising edge of the debounced level).
  - Releases (1->0) generate nothing.
  - A button held through reset release generates one event once debounced.
- Register map (full 32-bit address compare):
  - 0x1, R: {zero, sw_stable}
  - 0x2, R: {zero, btn_stable}
  - 0x3, R: {zero, btn_event}
  - 0x3, W: write-1-to-clear of btn_event using io_write_value[BTN_WIDTH-1:0]
  - All other addresses: read returns 0; writes are ignored.
  - No address overlaps 0x4, which is the LED write decode at top.
- Read timing:
  - io_read_value updates on the clk edge where io_read_en = 1 (1-cycle latency).
  - It holds its value while io_read_en = 0.
  - Reads have no side effects. Reading 0x3 does not clear.
- Simultaneous W1C and new event on the same bit in the same cycle: set wins, bit stays 1. Other bits clear normally.
- Simultaneous read and write of 0x3: the read returns the pre-write value.
- btn_irq is registered: 1 cycle after btn_event becomes non-zero; it drops 1 cycle after btn_event becomes 0.
- Reset mid-debounce discards partial counts. Levels restart from 0.

Decomposition:
- Package io_map_pkg:
  - address constants IO_ADDR_SW = 1, IO_ADDR_BTN = 2, IO_ADDR_BTN_EVT = 3, IO_ADDR_LED = 4
  - the 3-bit debounce counter width constant
- Sub-module debounce_bit: one bit covering the 2-flop sync, counter and stable flop. Inputs are clk, rst_n, tick, raw; output is stable. It is instantiated SW_WIDTH + BTN_WIDTH times via generate.
- Prescaler, event logic and bus decode live in the top of this block.

Test Plan (TICK_CYCLES = 4, STABLE_TICKS = 3 unless noted):
- Reset: assert rst_n = 0 with sw_raw = 0xFFFF mid-run -> io_read_value, btn_irq, debounced levels read 0 immediately (asynchronous). After release, a read of 0x1 returns 0x0000 until 3 ticks elapse, then 0x0000FFFF.
- Glitch reject: btn_raw[0] high for 2 ticks, then low -> reads of 0x2 and 0x3 stay 0, btn_irq stays 0. Held high for 3 ticks -> 0x2 reads 0x1, 0x3 reads 0x1, btn_irq = 1.
- Sticky + W1C: press btn[1] and btn[3] -> 0x3 reads 0x0A. Release both -> still 0x0A. Write 0x3 = 0x08 -> reads 0x02. Write 0x3 = 0x02 -> reads 0x00, btn_irq drops the next cycle.
- Set-wins collision: align the btn[2] debounced rise with a write of 0x3 = 0x04 in the same cycle -> 0x3 reads 0x04 afterwards.
- Bus decode: read 0x0, 0x4, 0x80000001 -> 0. Writes to 0x1, 0x2, 0x4 leave the event register unchanged. io_read_value holds its last value while io_read_en = 0.
- Switch bounce: toggle sw_raw[7] every cycle for 20 cycles, then settle at 1 -> 0x1 bit 7 becomes 1 exactly 3 ticks after settling, with no intermediate toggles.
